// File: rtl/alu_seq.sv
// Handshaked ALU: captures a/b/op on a valid/ready handshake and holds result, flags and error until consumed.
// Multiply runs as an iterative shift-add over WIDTH cycles; seg shows result[3:0] on a hex 7-segment digit.
module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             err,
  output logic [6:0]       seg
);

  localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW  = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_nxt;
  logic               accept;
  logic               is_mul;
  logic [SHW-1:0]     sh;
  logic [WIDTH:0]     sum, diff;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry, alu_ovf, alu_err;
  logic [2*WIDTH-1:0] acc, ma, acc_step;
  logic [WIDTH-1:0]   mb;
  logic [CW-1:0]      cnt;

  assign is_mul   = (op == 4'd11);
  assign acc_step = mb[0] ? (acc + ma) : acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // DONE forwards out_ready to in_ready so a consumed result can be replaced in the same cycle
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) state_nxt = is_mul ? BUSY : DONE;
      end
      BUSY: begin
        if (cnt == CW'(1)) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        accept    = in_valid & out_ready;
        if (out_ready) begin
          if (in_valid) state_nxt = is_mul ? BUSY : DONE;
          else          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sh        = b[SHW-1:0];
    sum       = {1'b0, a} + {1'b0, b};
    diff      = {1'b0, a} - {1'b0, b};
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_err   = 1'b0;
    case (op)
      4'd0: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
        alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'd1: begin
        alu_res   = diff[WIDTH-1:0];
        alu_carry = diff[WIDTH];
        alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      4'd2:  alu_res = ~a;
      4'd3:  alu_res = a & b;
      4'd4:  alu_res = a | b;
      4'd5:  alu_res = a ^ b;
      4'd6:  alu_res = WIDTH'($signed(a) < $signed(b));
      4'd7:  alu_res = WIDTH'(a == b);
      4'd8:  alu_res = a << sh;
      4'd9:  alu_res = a >> sh;
      4'd10: alu_res = $signed(a) >>> sh;
      4'd11: alu_res = '0;
      default: alu_err = 1'b1;
    endcase
  end

  // result/flags/err change only when a new result lands; a multiply in flight leaves them untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      flags  <= 4'b0100;
      err    <= 1'b0;
      acc    <= '0;
      ma     <= '0;
      mb     <= '0;
      cnt    <= '0;
    end else if (accept) begin
      if (is_mul) begin
        acc <= '0;
        ma  <= {{WIDTH{1'b0}}, a};
        mb  <= b;
        cnt <= CW'(WIDTH);
      end else begin
        result <= alu_res;
        flags  <= alu_err ? 4'b0000
                          : {alu_res[WIDTH-1], alu_res == '0, alu_carry, alu_ovf};
        err    <= alu_err;
      end
    end else if (state == BUSY) begin
      acc <= acc_step;
      ma  <= ma << 1;
      mb  <= mb >> 1;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        result <= acc_step[WIDTH-1:0];
        flags  <= {acc_step[WIDTH-1], acc_step[WIDTH-1:0] == '0,
                   |acc_step[2*WIDTH-1:WIDTH], 1'b0};
        err    <= 1'b0;
      end
    end
  end

  always_comb begin
    case (result[3:0])
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: a WIDTH=4 instance checked through a result scoreboard,
// plus a WIDTH=8 instance for multiply latency and carry.
module tb_alu_seq;

  typedef struct {
    logic [3:0] result;
    logic [3:0] flags;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b0, err4;
  logic [3:0] a4 = '0, b4 = '0, op4 = '0, result4, flags4;
  logic [6:0] seg4;

  logic       in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b0, err8;
  logic [7:0] a8 = '0, b8 = '0, result8;
  logic [3:0] op8 = '0, flags8;
  logic [6:0] seg8;

  int   checks = 0;
  int   failures = 0;
  exp_t sb_q[$];
  exp_t sb_exp;

  alu_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .op(op4), .out_valid(out_valid4), .out_ready(out_ready4),
    .result(result4), .flags(flags4), .err(err4), .seg(seg4)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .op(op8), .out_valid(out_valid8), .out_ready(out_ready8),
    .result(result8), .flags(flags8), .err(err8), .seg(seg8)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_model(input logic [3:0] v);
    logic [6:0] tbl [16];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return tbl[v];
  endfunction

  // integer reference model of the 4-bit ALU
  function automatic exp_t model4(input int a, input int b, input int op);
    exp_t e;
    int sa, sb, s, r, sh;
    bit c, v, er;
    sa = (a > 7) ? a - 16 : a;
    sb = (b > 7) ? b - 16 : b;
    sh = b % 4;
    r = 0; c = 0; v = 0; er = 0; s = 0;
    case (op)
      0:  begin r = a + b; c = (r > 15); s = sa + sb; v = (s > 7) || (s < -8); end
      1:  begin r = a - b; c = (a < b);  s = sa - sb; v = (s > 7) || (s < -8); end
      2:  r = 15 - a;
      3:  r = a & b;
      4:  r = a | b;
      5:  r = a ^ b;
      6:  r = (sa < sb) ? 1 : 0;
      7:  r = (a == b) ? 1 : 0;
      8:  r = a * (1 << sh);
      9:  r = a / (1 << sh);
      10: r = sa >>> sh;
      11: begin r = a * b; c = (r > 15); end
      default: er = 1;
    endcase
    r = r & 15;
    e.result = 4'(r);
    e.err    = er;
    e.flags  = er ? 4'b0000 : {r >= 8, r == 0, c, v};
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid4 && out_ready4) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL sb_underflow: result=%h flags=%b with no expected entry", result4, flags4);
      end else begin
        sb_exp = sb_q.pop_front();
        if (result4 !== sb_exp.result || flags4 !== sb_exp.flags || err4 !== sb_exp.err ||
            seg4 !== seg_model(sb_exp.result)) begin
          failures++;
          $display("[TB] FAIL sb_compare: got r=%h f=%b e=%b seg=%b, want r=%h f=%b e=%b seg=%b",
                   result4, flags4, err4, seg4, sb_exp.result, sb_exp.flags, sb_exp.err,
                   seg_model(sb_exp.result));
        end
      end
    end
  end

  // starts just after a posedge; returns #1 after the accepting edge
  task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                       output int waited);
    in_valid4 = 1'b1; a4 = a; b4 = b; op4 = op;
    waited = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready4) break;
      waited++;
      if (waited > 50) begin
        checks++; failures++;
        $display("[TB] FAIL accept_timeout: in_ready stayed %b for op=%0d", in_ready4, op);
        break;
      end
    end
    if (waited <= 50) sb_q.push_back(model4(int'(a), int'(b), int'(op)));
    @(posedge clk); #1;
    in_valid4 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({out_valid4, result4, flags4, err4, seg4} !== {1'b0, 4'h0, 4'b0100, 1'b0, 7'b1000000}) begin
      failures++;
      $display("[TB] FAIL reset_w4: ov=%b r=%h f=%b e=%b seg=%b, want 0 0 0100 0 1000000",
               out_valid4, result4, flags4, err4, seg4);
    end
    checks++;
    if ({out_valid8, result8, flags8, err8, seg8} !== {1'b0, 8'h00, 4'b0100, 1'b0, 7'b1000000}) begin
      failures++;
      $display("[TB] FAIL reset_w8: ov=%b r=%h f=%b e=%b seg=%b, want 0 00 0100 0 1000000",
               out_valid8, result8, flags8, err8, seg8);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_release: in_ready=%b out_valid=%b, want 1 0", in_ready4, out_valid4);
    end
  endtask

  task automatic test_add();
    int w;
    out_ready4 = 1'b0;
    send4(4'd7, 4'd9, 4'd0, w);
    checks++;
    if ({out_valid4, result4, flags4, seg4} !== {1'b1, 4'h0, 4'b0110, 7'b1000000}) begin
      failures++;
      $display("[TB] FAIL add_7_9: ov=%b r=%h f=%b seg=%b, want 1 0 0110 1000000",
               out_valid4, result4, flags4, seg4);
    end
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid4 !== 1'b0 || result4 !== 4'h0 || flags4 !== 4'b0110) begin
      failures++;
      $display("[TB] FAIL hold_after_consume: ov=%b r=%h f=%b, want 0 0 0110", out_valid4, result4, flags4);
    end
  endtask

  task automatic test_sub_ovf();
    int w;
    out_ready4 = 1'b1;
    send4(4'd3, 4'd5, 4'd1, w);
    checks++;
    if (result4 !== 4'hE || flags4 !== 4'b1010) begin
      failures++;
      $display("[TB] FAIL sub_3_5: r=%h f=%b, want e 1010", result4, flags4);
    end
    send4(4'd7, 4'd1, 4'd0, w);
    checks++;
    if (result4 !== 4'h8 || flags4 !== 4'b1001) begin
      failures++;
      $display("[TB] FAIL add_ovf: r=%h f=%b, want 8 1001", result4, flags4);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int w;
    out_ready4 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send4(4'(i * 3 + 1), 4'(i * 5 + 2), 4'(3 + (i % 3)), w);
      checks++;
      if (out_valid4 !== 1'b1 || w !== 0) begin
        failures++;
        $display("[TB] FAIL b2b_gap: step=%0d out_valid=%b waited=%0d, want 1 0", i, out_valid4, w);
      end
    end
    send4(4'd6, 4'd6, 4'd7, w);
    checks++;
    if (result4 !== 4'h1 || w !== 0) begin
      failures++;
      $display("[TB] FAIL b2b_eq: r=%h waited=%0d, want 1 0", result4, w);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int w;
    out_ready4 = 1'b0;
    send4(4'd5, 4'd3, 4'd4, w);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid4 !== 1'b1 || in_ready4 !== 1'b0 || result4 !== sb_q[0].result ||
          flags4 !== sb_q[0].flags) begin
        failures++;
        $display("[TB] FAIL backpressure: cyc=%0d ov=%b ir=%b r=%h f=%b, want 1 0 %h %b",
                 i, out_valid4, in_ready4, result4, flags4, sb_q[0].result, sb_q[0].flags);
      end
    end
    @(posedge clk); #1;
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid4 !== 1'b0 || sb_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: out_valid=%b pending=%0d, want 0 0", out_valid4, sb_q.size());
    end
  endtask

  task automatic test_err_sra();
    int w;
    out_ready4 = 1'b1;
    send4(4'd2, 4'd3, 4'd13, w);
    checks++;
    if (err4 !== 1'b1 || result4 !== 4'h0 || flags4 !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL illegal_op: e=%b r=%h f=%b, want 1 0 0000", err4, result4, flags4);
    end
    send4(4'b1000, 4'd2, 4'd10, w);
    checks++;
    if (result4 !== 4'b1110 || err4 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL sra: r=%b e=%b, want 1110 0", result4, err4);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int w;
    out_ready4 = 1'b1;
    for (int i = 0; i < 40; i++)
      send4(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), w);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic mul8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] want_r,
                      input logic [3:0] want_f);
    int cyc;
    out_ready8 = 1'b0;
    in_valid8 = 1'b1; a8 = a; b8 = b; op8 = 4'd11;
    @(negedge clk);
    checks++;
    if (in_ready8 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mul8_ready: in_ready=%b, want 1", in_ready8);
    end
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    cyc = 0;
    while (!out_valid8 && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc !== 8 || result8 !== want_r || flags8 !== want_f || err8 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mul8: cycles=%0d r=%0d f=%b e=%b, want 8 %0d %b 0",
               cyc, result8, flags8, err8, want_r, want_f);
    end
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
  endtask

  task automatic test_mul8();
    mul8(8'd13, 8'd11, 8'd143, 4'b1000);
    mul8(8'd20, 8'd20, 8'd144, 4'b1010);
  endtask

  task automatic test_reset_mid_mul();
    int seen;
    out_ready4 = 1'b1;
    in_valid4 = 1'b1; a4 = 4'd3; b4 = 4'd5; op4 = 4'd11;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready4, out_valid4, result4, flags4, err4, seg4} !==
        {1'b1, 1'b0, 4'h0, 4'b0100, 1'b0, 7'b1000000}) begin
      failures++;
      $display("[TB] FAIL reset_mid_mul: ir=%b ov=%b r=%h f=%b e=%b seg=%b, want 1 0 0 0100 0 1000000",
               in_ready4, out_valid4, result4, flags4, err4, seg4);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid4) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("[TB] FAIL mul_discarded: out_valid high %0d cycles after reset, want 0", seen);
    end
  endtask

  initial begin
    $display("[TB] alu_seq bench start");
    test_reset();
    test_add();
    test_sub_ovf();
    test_back_to_back();
    test_backpressure();
    test_err_sra();
    test_random();
    test_mul8();
    test_reset_mid_mul();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL sb_leftover: %0d expected results never produced, want 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
